// File: rtl/o64_loader_pkg.sv
// ============================================================================
// Module : o64_loader_pkg
// Brief  : Shared constants, chunk-count helper and state encoding for the
//          o64 operand loader.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package o64_loader_pkg;

  localparam int VEC_W = 130;

  function automatic int nchunk(input int vec_w, input int chunk_w);
    return (vec_w + chunk_w - 1) / chunk_w;
  endfunction

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/o64_chunk_ctr.sv
// ============================================================================
// Module : o64_chunk_ctr
// Brief  : Chunk index counter with clear, increment and last-index flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module o64_chunk_ctr #(
  parameter int N = 17,
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] idx_o,
  output logic         is_last_idx_o
);

  logic [W-1:0] idx_q;
  logic [W-1:0] idx_d;

  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (inc_i) begin
      idx_d = idx_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o         = idx_q;
  assign is_last_idx_o = (idx_q == W'(N - 1));

endmodule

`default_nettype wire

// File: rtl/o64_operand_loader.sv
// ============================================================================
// Module : o64_operand_loader
// Brief  : Deserialises a chunk stream into the 130-bit o64 operand vector,
//          checks frame length and keeps frame/drop counters.
//          Optional macro O64_LOADER_PARITY_EN adds per-chunk even parity.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module o64_operand_loader
  import o64_loader_pkg::*;
#(
  parameter int CHUNK_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CHUNK_W-1:0] s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [VEC_W-1:0]   m_vec,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               err_short,
  output logic               err_long,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [CNT_W-1:0]   drop_cnt
`ifdef O64_LOADER_PARITY_EN
  ,
  input  logic               s_par,
  output logic               err_par
`endif
);

  localparam int NCHUNK = nchunk(VEC_W, CHUNK_W);
  localparam int IDX_W  = $clog2(NCHUNK + 1);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic               err_short_q, err_long_q;
  logic [IDX_W-1:0]   idx;
  logic               is_last_idx;
  logic [VEC_W-1:0]   slot_data;
  logic [VEC_W-1:0]   slot_sel;

  logic acc, fill_acc, frame_bad, ev_short, ev_long, ev_par, ev_good, ev_take;

  o64_chunk_ctr #(
    .N (NCHUNK),
    .W (IDX_W)
  ) u_ctr (
    .clk           (clk),
    .rst           (rst),
    .clr_i         ((acc && (s_last || (state_q == FILL && is_last_idx))) || ev_take),
    .inc_i         (fill_acc),
    .idx_o         (idx),
    .is_last_idx_o (is_last_idx)
  );

  // Bit i of the vector is owned by chunk i/CHUNK_W at chunk bit i%CHUNK_W.
  for (genvar i = 0; i < VEC_W; i++) begin : g_bit
    localparam int K = i / CHUNK_W;
    localparam int J = i % CHUNK_W;
    assign slot_data[i] = s_data[J];
    assign slot_sel[i]  = (idx == IDX_W'(K));
  end

`ifdef O64_LOADER_PARITY_EN
  logic bad_q, bad_d, err_par_q, par_mis;
  assign par_mis   = s_par ^ (^s_data);
  assign frame_bad = bad_q | par_mis;

  always_comb begin
    bad_d = bad_q;
    if (fill_acc) begin
      bad_d = (s_last || is_last_idx) ? 1'b0 : (bad_q | par_mis);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_q     <= 1'b0;
      err_par_q <= 1'b0;
    end else begin
      bad_q     <= bad_d;
      err_par_q <= ev_par;
    end
  end

  assign err_par = err_par_q;
`else
  assign frame_bad = 1'b0;
`endif

  always_comb begin
    acc      = s_valid && s_ready;
    fill_acc = acc && (state_q == FILL);
    ev_short = fill_acc && s_last && !is_last_idx;
    ev_long  = fill_acc && !s_last && is_last_idx;
    ev_par   = fill_acc && s_last && is_last_idx && frame_bad;
    ev_good  = fill_acc && s_last && is_last_idx && !frame_bad;
    ev_take  = (state_q == HOLD) && m_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: begin
        if (ev_good) begin
          state_d = HOLD;
        end else if (ev_long) begin
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (m_ready) state_d = FILL;
      end
      DRAIN: begin
        if (acc && s_last) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    s_ready = 1'b1;
    m_valid = 1'b0;
    case (state_q)
      HOLD: begin
        s_ready = 1'b0;
        m_valid = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    vec_d       = fill_acc ? ((vec_q & ~slot_sel) | (slot_data & slot_sel)) : vec_q;
    frame_cnt_d = ev_take ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
    drop_cnt_d  = (ev_short || ev_long || ev_par) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      vec_q       <= vec_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_short_q <= ev_short;
      err_long_q  <= ev_long;
    end
  end

  assign m_vec     = vec_q;
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

`default_nettype wire

// File: tb/tb_o64_operand_loader.sv
// ============================================================================
// Module : tb_o64_operand_loader
// Brief  : Directed self-checking bench for o64_operand_loader (CHUNK_W=8).
//          Parity scenario runs when O64_LOADER_PARITY_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_o64_operand_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_ready;
  logic [129:0] m_vec;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         err_short;
  logic         err_long;
  logic [15:0]  frame_cnt;
  logic [15:0]  drop_cnt;
`ifdef O64_LOADER_PARITY_EN
  logic         s_par = 1'b0;
  logic         err_par;
`endif

  int checks = 0;
  int errors = 0;

  // Monitor results from the most recent send_frame call
  int n_short, n_long, n_par, n_mvalid, n_notready, long_at, par_at;

  o64_operand_loader #(.CHUNK_W(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .m_vec     (m_vec),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .err_short (err_short),
    .err_long  (err_long),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
`ifdef O64_LOADER_PARITY_EN
    ,
    .s_par     (s_par),
    .err_par   (err_par)
`endif
  );

  always #5 clk = ~clk;

  // Sends n chunks from p (chunk k = p[8k+7:8k]); s_last on chunk index last_at;
  // chunk index bad_k gets inverted parity. Observes outputs after each edge.
  task automatic send_frame(input logic [159:0] p, input int n, input int last_at, input int bad_k);
    n_short = 0; n_long = 0; n_par = 0; n_mvalid = 0; n_notready = 0; long_at = -1; par_at = -1;
    for (int k = 0; k < n; k++) begin
      if (!s_ready) n_notready++;
      s_data  = p[k*8 +: 8];
      s_valid = 1'b1;
      s_last  = (k == last_at);
`ifdef O64_LOADER_PARITY_EN
      s_par   = (^s_data) ^ (k == bad_k);
`endif
      if (k < n - 1 && m_valid) n_mvalid++;
      @(posedge clk); #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (err_short) n_short++;
      if (err_long) begin n_long++; long_at = k + 1; end
`ifdef O64_LOADER_PARITY_EN
      if (err_par) begin n_par++; par_at = k + 1; end
`endif
    end
  endtask

  task automatic handshake();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b exp 0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b exp 1", s_ready); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
    checks++; if (m_vec !== 130'd0) begin errors++; $display("FAIL reset_m_vec got %h exp 0", m_vec); end
    checks++; if ({err_short, err_long} !== 2'b00) begin errors++; $display("FAIL reset_err got %b exp 00", {err_short, err_long}); end
  endtask

  task automatic test_basic();
    logic [159:0] p;
    logic [129:0] exp_v;
    p = '0; p[1] = 1'b1; p[65] = 1'b1;
    exp_v = '0; exp_v[1] = 1'b1; exp_v[65] = 1'b1;
    send_frame(p, 17, 16, -1);
    checks++; if (n_mvalid !== 0) begin errors++; $display("FAIL basic_early_valid got %0d exp 0", n_mvalid); end
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL basic_m_valid got %b exp 1", m_valid); end
    checks++; if (m_vec !== exp_v) begin errors++; $display("FAIL basic_m_vec got %h exp %h", m_vec, exp_v); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_hold got %b exp 0", s_ready); end
    handshake();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", m_valid); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt got %0d exp 1", frame_cnt); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_s_ready_after got %b exp 1", s_ready); end
  endtask

  task automatic test_top_chunk();
    logic [159:0] p;
    logic [129:0] exp_v;
    p = '0; p[135:128] = 8'hFF;
    exp_v = '0; exp_v[129:128] = 2'b11;
    send_frame(p, 17, 16, -1);
    checks++; if (m_vec !== exp_v) begin errors++; $display("FAIL top_chunk_m_vec got %h exp %h", m_vec, exp_v); end
    handshake();
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL top_chunk_frame_cnt got %0d exp 2", frame_cnt); end
  endtask

  task automatic test_backpressure();
    logic [159:0] p;
    logic [129:0] exp_v;
    p = 160'h0000_0000_0003_A5C3_1234_5678_9ABC_DEF0_0F1E_2D3C;
    exp_v = 130'h3_A5C3_1234_5678_9ABC_DEF0_0F1E_2D3C;
    send_frame(p, 17, 16, -1);
    for (int c = 0; c < 5; c++) begin
      checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid cyc %0d got %b exp 1", c, m_valid); end
      checks++; if (m_vec !== exp_v) begin errors++; $display("FAIL bp_m_vec cyc %0d got %h exp %h", c, m_vec, exp_v); end
      checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready cyc %0d got %b exp 0", c, s_ready); end
      @(posedge clk); #1;
    end
    handshake();
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_s_ready_release got %b exp 1", s_ready); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL bp_frame_cnt got %0d exp 3", frame_cnt); end
  endtask

  task automatic test_short();
    logic [159:0] p;
    logic [129:0] exp_v;
    p = {160{1'b1}};
    send_frame(p, 10, 9, -1);
    checks++; if (n_short !== 1) begin errors++; $display("FAIL short_pulses got %0d exp 1", n_short); end
    @(posedge clk); #1;
    checks++; if (err_short !== 1'b0) begin errors++; $display("FAIL short_pulse_width got %b exp 0", err_short); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL short_drop_cnt got %0d exp 1", drop_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL short_m_valid got %b exp 0", m_valid); end
    p = 160'h0000_0000_0001_0203_0405_0607_0809_0A0B_0C0D_0E0F;
    exp_v = 130'h1_0203_0405_0607_0809_0A0B_0C0D_0E0F;
    send_frame(p, 17, 16, -1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL short_next_valid got %b exp 1", m_valid); end
    checks++; if (m_vec !== exp_v) begin errors++; $display("FAIL short_next_m_vec got %h exp %h", m_vec, exp_v); end
    handshake();
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL short_frame_cnt got %0d exp 4", frame_cnt); end
  endtask

  task automatic test_long();
    logic [159:0] p;
    logic [129:0] exp_v;
    p = {160{1'b1}};
    send_frame(p, 20, 19, -1);
    checks++; if (n_long !== 1) begin errors++; $display("FAIL long_pulses got %0d exp 1", n_long); end
    checks++; if (long_at !== 17) begin errors++; $display("FAIL long_pulse_at got %0d exp 17", long_at); end
    checks++; if (n_short !== 0) begin errors++; $display("FAIL long_short_pulses got %0d exp 0", n_short); end
    checks++; if (n_notready !== 0) begin errors++; $display("FAIL long_drain_ready got %0d stalls exp 0", n_notready); end
    checks++; if (drop_cnt !== 16'd2) begin errors++; $display("FAIL long_drop_cnt got %0d exp 2", drop_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL long_m_valid got %b exp 0", m_valid); end
    p = '0; p[0] = 1'b1; p[129] = 1'b1;
    exp_v = '0; exp_v[0] = 1'b1; exp_v[129] = 1'b1;
    send_frame(p, 17, 16, -1);
    checks++; if (m_vec !== exp_v) begin errors++; $display("FAIL long_next_m_vec got %h exp %h", m_vec, exp_v); end
    handshake();
    checks++; if (frame_cnt !== 16'd5) begin errors++; $display("FAIL long_frame_cnt got %0d exp 5", frame_cnt); end
  endtask

  task automatic test_reset_mid();
    logic [159:0] p;
    logic [129:0] exp_v;
    p = {160{1'b1}};
    send_frame(p, 5, -1, -1);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_drop_cnt got %0d exp 0", drop_cnt); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_s_ready got %b exp 1", s_ready); end
    p = 160'h0000_0000_0002_1122_3344_5566_7788_99AA_BBCC_DDEE;
    exp_v = 130'h2_1122_3344_5566_7788_99AA_BBCC_DDEE;
    send_frame(p, 17, 16, -1);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rstmid_m_valid got %b exp 1", m_valid); end
    checks++; if (m_vec !== exp_v) begin errors++; $display("FAIL rstmid_m_vec got %h exp %h", m_vec, exp_v); end
    handshake();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL rstmid_frame_cnt_after got %0d exp 1", frame_cnt); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_drop_after got %0d exp 0", drop_cnt); end
  endtask

`ifdef O64_LOADER_PARITY_EN
  task automatic test_parity();
    logic [159:0] p;
    p = 160'h0000_0000_0001_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    send_frame(p, 17, 16, 2);
    checks++; if (n_par !== 1) begin errors++; $display("FAIL par_pulses got %0d exp 1", n_par); end
    checks++; if (par_at !== 17) begin errors++; $display("FAIL par_pulse_at got %0d exp 17", par_at); end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL par_drop_cnt got %0d exp 1", drop_cnt); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL par_m_valid got %b exp 0", m_valid); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL par_frame_cnt got %0d exp 1", frame_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_top_chunk();
    test_backpressure();
    test_short();
    test_long();
    test_reset_mid();
`ifdef O64_LOADER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
